// File: rtl/floor_wr.sv
// rtl/floor_wr.sv - raster-order rectangle write engine for the 12-bit pixel RAM
// Optional build macro: FLOOR_WR_COLORKEY_EN (12'h0F0 pixels become transparent).
module floor_wr #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 20,
    parameter int STRIDE     = 320,
    parameter int XY_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [XY_WIDTH-1:0]   x0,
    input  logic [XY_WIDTH-1:0]   y0,
    input  logic [XY_WIDTH-1:0]   w,
    input  logic [XY_WIDTH-1:0]   h,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);

    logic [1:0]            state_q, state_d;
    logic [XY_WIDTH-1:0]   x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [XY_WIDTH-1:0]   col_q, col_d, row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] load_base;
    logic                  col_last, row_last, key_hit;

    // The only multiply of a transfer; later rows advance by adding STRIDE.
    assign load_base = ADDR_WIDTH'(y0_q) * STRIDE_A + ADDR_WIDTH'(x0_q);
    assign col_last  = (col_q == w_q - XY_WIDTH'(1));
    assign row_last  = (row_q == h_q - XY_WIDTH'(1));

`ifdef FLOOR_WR_COLORKEY_EN
    assign key_hit = (s_data == DATA_WIDTH'(12'h0F0));
`else
    assign key_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = w;
                    h_d     = h;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                row_base_d = load_base;
                col_d      = '0;
                row_d      = '0;
                state_d    = (w_q == '0 || h_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (s_valid) begin
                    // Keyed pixels still consume an address slot.
                    we_d    = ~key_hit;
                    waddr_d = row_base_q + ADDR_WIDTH'(col_q);
                    wdata_d = s_data;
                    if (col_last) begin
                        col_d      = '0;
                        row_d      = row_q + XY_WIDTH'(1);
                        row_base_d = row_base_q + STRIDE_A;
                        if (row_last) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        col_d = col_q + XY_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign s_ready = (state_q == S_RUN);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;

endmodule

// File: tb/tb_floor_wr.sv
// tb/tb_floor_wr.sv - scoreboard bench for floor_wr against a geometric address model
module tb_floor_wr;

    localparam int STRIDE = 320;

`ifdef FLOOR_WR_COLORKEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  x0 = '0, y0 = '0, w = '0, h = '0;
    logic        s_valid = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_ready, we, busy, done;
    logic [19:0] waddr;
    logic [11:0] wdata;

    floor_wr #(.DATA_WIDTH(12), .ADDR_WIDTH(20), .STRIDE(STRIDE), .XY_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic [11:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] ovr[$];
    int          zero_done = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {12'd0, waddr}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("waddr", {12'd0, waddr}, {12'd0, e.addr});
                chk("wdata", {20'd0, wdata}, {20'd0, e.data});
                chk("done_with_write", {31'd0, done}, {31'd0, e.last});
            end
        end else if (done) begin
            chk("writeless_done_expected", (zero_done > 0) ? 32'd1 : 32'd0, 32'd1);
            if (zero_done > 0) zero_done--;
        end
        if (prev_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
        prev_done = done;
    end

    // vpct < 0 toggles s_valid every cycle; abort_after >= 0 stops after that many beats.
    task automatic run_rect(input int ax0, input int ay0, input int aw, input int ah,
                            input int vpct, input int abort_after, input bit mid_start);
        logic [11:0] dat[$];
        int n, k, cyc, lim;
        bit mid_done;
        n = aw * ah;
        mid_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ovr.size() != 0) dat.push_back(ovr.pop_front());
            else dat.push_back(12'($urandom));
        end
        lim = (abort_after >= 0) ? abort_after : n;
        for (int r = 0; r < ah; r++) begin
            for (int c = 0; c < aw; c++) begin
                int   idx;
                exp_t e;
                idx = r * aw + c;
                if (idx < lim) begin
                    e.addr = 20'(((ay0 + r) * STRIDE + ax0 + c) % (1 << 20));
                    e.data = dat[idx];
                    e.last = (abort_after < 0) && (idx == n - 1);
                    if (KEY_EN && dat[idx] == 12'h0F0) begin
                        if (e.last) zero_done++;
                    end else begin
                        exp_q.push_back(e);
                    end
                end
            end
        end
        if (n == 0) zero_done++;

        @(posedge clk); #1;
        x0 = 10'(ax0); y0 = 10'(ay0); w = 10'(aw); h = 10'(ah);
        start = 1'b1;
        s_valid = 1'b1;
        s_data = 12'hABC;
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ready", {31'd0, s_ready}, 32'd0);
        if (n == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
            chk("zero_done_t2", {31'd0, done}, 32'd1);
            chk("zero_ready", {31'd0, s_ready}, 32'd0);
            chk("zero_we", {31'd0, we}, 32'd0);
            return;
        end
        @(posedge clk); #1;
        chk("run_ready", {31'd0, s_ready}, 32'd1);
        k = 0;
        cyc = 0;
        while (k < lim && cyc < 4000) begin
            s_valid = (vpct < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) < vpct);
            s_data = dat[k];
            if (mid_start && k == 2 && !mid_done) begin
                start = 1'b1;
                x0 = 10'd100; y0 = 10'd7; w = 10'd9; h = 10'd9;
                mid_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (s_valid && s_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        chk("beats_accepted", k, lim);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {12'd0, waddr}, 32'd0);
        chk("rst_wdata", {20'd0, wdata}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        for (int i = 1; i <= 6; i++) ovr.push_back(12'(i));
        run_rect(2, 1, 3, 2, 100, -1, 1'b0);
        for (int i = 1; i <= 6; i++) ovr.push_back(12'(i));
        run_rect(2, 1, 3, 2, -1, -1, 1'b0);

        run_rect(0, 0, 0, 5, 100, -1, 1'b0);
        run_rect(4, 4, 3, 0, 100, -1, 1'b0);

        run_rect(5, 3, 4, 3, 70, -1, 1'b1);

        run_rect(10, 10, 4, 2, 100, 3, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_we", {31'd0, we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, s_ready}, 32'd0);
        reset = 1'b0;
        run_rect(0, 0, 1, 1, 100, -1, 1'b0);

        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        w = 10'd2; h = 10'd2;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("reset_beats_start", {31'd0, busy}, 32'd0);

        ovr.push_back(12'h001);
        ovr.push_back(12'h0F0);
        ovr.push_back(12'h003);
        run_rect(0, 0, 3, 1, 100, -1, 1'b0);
        ovr.push_back(12'h0F0);
        run_rect(20, 2, 1, 1, 100, -1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            run_rect($urandom_range(1023), $urandom_range(1023),
                     $urandom_range(6, 1), $urandom_range(4, 1),
                     $urandom_range(100, 30), -1, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("writeless_done_left", zero_done, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/floor_wr.md
# floor_wr

Raster-order write engine for the floor/tile pixel store. Accepts a rectangle (origin, width, height) and a valid/ready pixel stream, then generates one synchronous write per accepted pixel into the write port of the 12-bit RGB pixel RAM. The display path reads the same RAM through its one-cycle synchronous read port. This block is that RAM's loader and updater.

## Interface
Parameters:
- DATA_WIDTH, 12, pixel width (RGB444)
- ADDR_WIDTH, 20, RAM address width
- STRIDE, 320, pixels per RAM row
- XY_WIDTH, 10, width of x0/y0/w/h

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- x0, y0  in  XY_WIDTH  rectangle origin, sampled with start
- w, h  in  XY_WIDTH  rectangle size in pixels, sampled with start
- s_valid  in  1  pixel stream valid
- s_data  in  DATA_WIDTH  pixel value
- s_ready  out  1  engine can accept a pixel
- we  out  1  RAM write enable
- waddr  out  ADDR_WIDTH  RAM write address
- wdata  out  DATA_WIDTH  RAM write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: busy=0, s_ready=0. start=1 latches x0/y0/w/h and moves to LOAD.
- LOAD (1 cycle): row_base <= y0*STRIDE + x0 (mod 2^ADDR_WIDTH); col, row <= 0. If w==0 or h==0, go to DONE with no writes. Otherwise go to RUN.
- RUN: s_ready=1. A beat is accepted when s_valid & s_ready. Each accepted beat registers we=1, waddr=row_base+col, wdata=s_data for the next cycle.
  - After each beat, col increments.
  - When col==w-1, col<=0, row increments, and row_base += STRIDE.
  - When the beat at col==w-1 and row==h-1 is accepted, go to DONE. s_ready drops the following cycle.
- DONE (1 cycle): done=1, then return to IDLE.
- The stream is never stalled by the RAM. A beat is accepted in any RUN cycle where s_valid=1. s_valid=0 inserts idle cycles (we=0).
- No clipping. Addresses wrap modulo 2^ADDR_WIDTH. Keeping the rectangle in bounds is the caller's job.
- Only one multiply per transfer (in LOAD). Row advance uses an add.

## Timing
- Reset values: we=0, waddr=0, wdata=0, s_ready=0, busy=0, done=0, FSM=IDLE.
- start at cycle T: LOAD at T+1, RUN (s_ready=1) from T+2. busy=1 from T+1 through the DONE cycle inclusive.
- Beat accepted at cycle N: we/waddr/wdata valid at N+1, for exactly one cycle.
- Final beat accepted at N: DONE at N+1. done=1 coincides with the final we. IDLE at N+2, and a new start is accepted at N+2.
- Zero-size rectangle: start at T, then DONE at T+2 with done=1 and no we.
- start while busy: ignored; the latched geometry is unchanged.
- Changing x0/y0/w/h after start has no effect on the current transfer.
- s_valid with s_ready=0: no acceptance and no write. Upstream holds the beat.
- reset mid-transfer: the next cycle has we=0, s_ready=0, busy=0, FSM=IDLE. The remaining beats are never written, and done does not pulse.
- reset and start in the same cycle: reset wins.

## Configuration
- FLOOR_WR_COLORKEY_EN defined: an accepted beat with s_data == 12'h0F0 produces we=0 in the next cycle. Address and counters still advance, so the pixel is transparent. done timing is unchanged.
- Not defined: every accepted beat is written.

## Test plan
- Basic rectangle: STRIDE=320, x0=2, y0=1, w=3, h=2, continuous s_valid with data 1..6 -> waddr 322,323,324,642,643,644 with wdata 1..6 on consecutive cycles. done coincides with the waddr=644 write. busy falls the next cycle.
- Bubbles: same geometry, s_valid toggling 1/0 -> same 6 writes in order, with we=0 in the bubble cycles. Total writes = 6.
- Zero size: w=0, h=5 -> done pulses at T+2, we never asserts, and s_ready stays 0.
- Start while busy: assert start with new x0=100 mid-transfer -> ignored. The transfer completes with the original addresses.
- Reset mid-transfer: reset after the 3rd write -> we, busy and s_ready are 0 the next cycle, and no done pulse. A following start with x0=0, y0=0, w=1, h=1 writes waddr 0.
- Color key (with FLOOR_WR_COLORKEY_EN): data 1, 12'h0F0, 3 at w=3, h=1, x0=y0=0 -> writes only at waddr 0 and 2. done fires at the cycle of the third beat's write slot.
